ibex_instr_mem_responder: RTL

Memory-side responder for the instruction fetch req/gnt/rvalid protocol: accepts word fetches, reads a single-cycle synchronous SRAM, and returns data or error responses in order after a programmable latency. Sits between the core's instruction fetch port and an on-chip instruction SRAM, and doubles as a latency/stall-injecting memory model for core-level benches. Supports up to `MaxOutstanding` in-flight requests.

---
 rtl/ibex_imem_resp_pkg.sv | 26 ++
 rtl/ibex_imem_resp_fifo.sv | 87 ++++++++
 rtl/ibex_instr_mem_responder.sv | 65 ++++++
 3 files changed

// File: rtl/ibex_imem_resp_pkg.sv
// Shared types and helpers for the instruction memory responder.
package ibex_imem_resp_pkg;

    // Width of the per-request latency field and of each entry countdown
    localparam int unsigned LatW = 4;

    // One in-flight response: error flag, captured read data, cycles left before it may issue
    typedef struct packed {
        logic            err;
        logic [31:0]     rdata;
        logic [LatW-1:0] cnt;
    } imem_resp_entry_t;

    // A fetch is erroneous when misaligned or outside [base, base + 4*words)
    function automatic logic addr_is_err(
        input logic [31:0] addr,
        input logic [31:0] base,
        input int unsigned words
    );
        logic [32:0] offset;
        offset = {1'b0, addr} - {1'b0, base};
        return (addr[1:0] != 2'b00) || offset[32] ||
               (offset >= ({1'b0, 32'(words)} << 2));
    endfunction

endpackage

// File: rtl/ibex_imem_resp_fifo.sv
// In-order store of accepted fetches; read data lands one cycle after allocation.
module ibex_imem_resp_fifo
    import ibex_imem_resp_pkg::*;
#(
    parameter int unsigned Depth = 2,
    localparam int unsigned IdxW = (Depth > 1) ? $clog2(Depth) : 1,
    localparam int unsigned OccW = $clog2(Depth + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push_i,
    input  logic            push_err_i,
    input  logic [LatW-1:0] push_cnt_i,
    input  logic            pop_i,
    input  logic [31:0]     mem_rdata_i,
    output logic            head_ready_o,
    output logic            head_err_o,
    output logic [31:0]     head_rdata_o,
    output logic [OccW-1:0] occ_o
);

    imem_resp_entry_t entries_q [Depth];
    logic [Depth-1:0] dvalid_q;
    logic [IdxW-1:0]  wr_ptr_q;
    logic [IdxW-1:0]  rd_ptr_q;
    logic [OccW-1:0]  occ_q;
    logic             pend_we_q;
    logic [IdxW-1:0]  pend_idx_q;
    imem_resp_entry_t head;
    logic             cap_now;

    function automatic logic [IdxW-1:0] ptr_inc(input logic [IdxW-1:0] p);
        return (p == IdxW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    // Entry storage, countdowns, late data capture and pointer/occupancy bookkeeping
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(Depth); i++) begin
                entries_q[i] <= '0;
            end
            dvalid_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            pend_we_q  <= 1'b0;
            pend_idx_q <= '0;
        end else begin
            for (int i = 0; i < int'(Depth); i++) begin
                if (entries_q[i].cnt != '0) begin
                    entries_q[i].cnt <= entries_q[i].cnt - 1'b1;
                end
            end
            if (pend_we_q) begin
                entries_q[pend_idx_q].rdata <= mem_rdata_i;
                dvalid_q[pend_idx_q]        <= 1'b1;
            end
            // A fresh allocation overrides any late write aimed at a slot freed this cycle
            if (push_i) begin
                entries_q[wr_ptr_q] <= '{err: push_err_i, rdata: 32'h0, cnt: push_cnt_i};
                dvalid_q[wr_ptr_q]  <= push_err_i;
                wr_ptr_q            <= ptr_inc(wr_ptr_q);
            end
            pend_we_q  <= push_i && !push_err_i;
            pend_idx_q <= wr_ptr_q;
            if (pop_i) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            unique case ({push_i, pop_i})
                2'b10:   occ_q <= occ_q + 1'b1;
                2'b01:   occ_q <= occ_q - 1'b1;
                default: ;
            endcase
        end
    end

    // Head may issue once its countdown expired and its data is stored or arriving now
    always_comb begin
        head         = entries_q[rd_ptr_q];
        cap_now      = pend_we_q && (pend_idx_q == rd_ptr_q);
        head_ready_o = (occ_q != '0) && (head.cnt == '0) && (dvalid_q[rd_ptr_q] || cap_now);
        head_err_o   = head.err;
        head_rdata_o = dvalid_q[rd_ptr_q] ? head.rdata : mem_rdata_i;
        occ_o        = occ_q;
    end

endmodule

// File: rtl/ibex_instr_mem_responder.sv
// Memory-side responder for instruction fetches with programmable response latency.
module ibex_instr_mem_responder
    import ibex_imem_resp_pkg::*;
#(
    parameter logic [31:0] MemBase        = 32'h0000_0000,
    parameter int unsigned MemWords       = 4096,
    parameter int unsigned MaxOutstanding = 2,
    localparam int unsigned AW = $clog2(MemWords)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            instr_req_i,
    input  logic [31:0]     instr_addr_i,
    output logic            instr_gnt_o,
    output logic            instr_rvalid_o,
    output logic [31:0]     instr_rdata_o,
    output logic            instr_err_o,
    input  logic            stall_i,
    input  logic [LatW-1:0] lat_i,
    output logic            mem_req_o,
    output logic [AW-1:0]   mem_addr_o,
    input  logic [31:0]     mem_rdata_i,
    output logic            busy_o
);

    localparam int unsigned OccW = $clog2(MaxOutstanding + 1);

    logic            addr_err;
    logic            retire;
    logic            head_err;
    logic [31:0]     head_rdata;
    logic [OccW-1:0] occ;
    logic [LatW-1:0] lat_cnt;

    ibex_imem_resp_fifo #(
        .Depth(MaxOutstanding)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (instr_gnt_o),
        .push_err_i  (addr_err),
        .push_cnt_i  (lat_cnt),
        .pop_i       (retire),
        .mem_rdata_i (mem_rdata_i),
        .head_ready_o(retire),
        .head_err_o  (head_err),
        .head_rdata_o(head_rdata),
        .occ_o       (occ)
    );

    // Grant, address decode, SRAM drive and response masking; a full FIFO may still grant on retire
    always_comb begin
        addr_err       = addr_is_err(instr_addr_i, MemBase, MemWords);
        lat_cnt        = (lat_i == '0) ? '0 : lat_i - 1'b1;
        instr_gnt_o    = instr_req_i && !stall_i && !rst_i &&
                         ((occ < OccW'(MaxOutstanding)) || retire);
        mem_req_o      = instr_gnt_o && !addr_err;
        mem_addr_o     = mem_req_o ? AW'((instr_addr_i - MemBase) >> 2) : '0;
        instr_rvalid_o = retire;
        instr_err_o    = retire && head_err;
        instr_rdata_o  = (retire && !head_err) ? head_rdata : '0;
        busy_o         = (occ != '0);
    end

endmodule
